// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings, arbiter states and burst beat-count helper.
package ahb_pkg;

  localparam int BeatW = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY   = 3'd1,
    NONSEQ = 3'd2,
    SEQ    = 3'd3
  } trans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_t;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    OWN   = 2'd1,
    BURST = 2'd2,
    LOCK  = 2'd3
  } state_t;

  // Undefined-length and single transfers report one beat so they never enter BURST.
  function automatic logic [BeatW-1:0] burst_beats(input burst_t b);
    case (b)
      WRAP4, INCR4:   burst_beats = BeatW'(4);
      WRAP8, INCR8:   burst_beats = BeatW'(8);
      WRAP16, INCR16: burst_beats = BeatW'(16);
      default:        burst_beats = BeatW'(1);
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter-side bus bundle: manager requests and granted-manager control in, grants out.
interface ahb_arbiter_if
  import ahb_pkg::*;
#(
  parameter int NumManagers = 4,
  parameter int OwnerWidth  = $clog2(NumManagers)
);

  logic [NumManagers-1:0] req;
  logic [NumManagers-1:0] lock;
  trans_t                 trans;
  burst_t                 burst;
  logic                   ready;
  logic [NumManagers-1:0] grant;
  logic [OwnerWidth-1:0]  owner;
  logic                   ownerValid;
  logic                   mastLock;

  modport master (
    output req, lock, trans, burst, ready,
    input  grant, owner, ownerValid, mastLock
  );

  modport slave (
    input  req, lock, trans, burst, ready,
    output grant, owner, ownerValid, mastLock
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first requester after the last owner, wrapping.
module ahb_rr_picker #(
  parameter int NumManagers = 4,
  parameter int OwnerWidth  = $clog2(NumManagers)
) (
  input  logic [NumManagers-1:0] req,
  input  logic [OwnerWidth-1:0]  last,
  output logic [OwnerWidth-1:0]  idx,
  output logic                   found
);

  logic [OwnerWidth-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NumManagers; i++) begin
      cand = OwnerWidth'((int'(last) + i) % NumManagers);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter that re-arbitrates only at legal handover points
// (IDLE, end of a fixed-length burst, or release of a locked sequence).
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NumManagers = 4,
  parameter int OwnerWidth  = $clog2(NumManagers)
) (
  input logic         clk,
  input logic         reset,
  ahb_arbiter_if.slave bus
);

  state_t                 state;
  logic [OwnerWidth-1:0]  lastOwner;
  logic [BeatW-1:0]       beatsLeft;
  logic [NumManagers-1:0] grant_p0;
  logic [OwnerWidth-1:0]  owner_p0;
  logic                   ownervalid_p0;
  logic                   mastlock_p0;

  logic                   hp;
  logic                   found;
  logic [OwnerWidth-1:0]  pick;
  logic                   accept;
  logic [BeatW-1:0]       beats;

  assign accept = bus.ready;
  assign beats  = burst_beats(bus.burst);

  ahb_rr_picker #(
    .NumManagers(NumManagers),
    .OwnerWidth (OwnerWidth)
  ) u_picker (
    .req  (bus.req),
    .last (lastOwner),
    .idx  (pick),
    .found(found)
  );

  always_comb begin
    hp = 1'b0;
    case (state)
      PARK:    hp = 1'b1;
      OWN:     hp = accept && (bus.trans == IDLE);
      BURST:   hp = accept && (beatsLeft == BeatW'(1)) &&
                    ((bus.trans == NONSEQ) || (bus.trans == SEQ));
      LOCK:    hp = accept && !bus.lock[owner_p0] && (bus.trans == IDLE);
      default: hp = 1'b0;
    endcase
  end

  // ---- arbitration / ownership register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PARK;
      lastOwner     <= OwnerWidth'(NumManagers - 1);
      beatsLeft     <= '0;
      grant_p0      <= NumManagers'(1);
      owner_p0      <= '0;
      ownervalid_p0 <= 1'b0;
      mastlock_p0   <= 1'b0;
    end else if (hp) begin
      beatsLeft <= '0;
      if (found) begin
        grant_p0      <= NumManagers'(1) << pick;
        owner_p0      <= pick;
        ownervalid_p0 <= 1'b1;
        lastOwner     <= pick;
        if (bus.lock[pick]) begin
          state       <= LOCK;
          mastlock_p0 <= 1'b1;
        end else begin
          state       <= OWN;
          mastlock_p0 <= 1'b0;
        end
      end else begin
        state         <= PARK;
        grant_p0      <= NumManagers'(1);
        owner_p0      <= '0;
        ownervalid_p0 <= 1'b0;
        mastlock_p0   <= 1'b0;
      end
    end else begin
      case (state)
        OWN: begin
          // A lock request at NONSEQ outranks burst tracking: locked sequences end only on IDLE.
          if (accept && (bus.trans == NONSEQ)) begin
            if (bus.lock[owner_p0]) begin
              state       <= LOCK;
              mastlock_p0 <= 1'b1;
            end else if (beats > BeatW'(1)) begin
              state     <= BURST;
              beatsLeft <= beats - BeatW'(1);
            end
          end
        end
        BURST: begin
          if (accept && (bus.trans == SEQ)) begin
            beatsLeft <= beatsLeft - BeatW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.grant      = grant_p0;
  assign bus.owner      = owner_p0;
  assign bus.ownerValid = ownervalid_p0;
  assign bus.mastLock   = mastlock_p0;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: stimulus pushes expected post-edge outputs, a monitor checks them.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic clk;
  logic reset;

  ahb_arbiter_if #(.NumManagers(4)) bus ();

  ahb_arbiter #(.NumManagers(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] expq[$];
  string      nameq[$];
  int         tests;
  int         fails;

  task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] l,
                      input trans_t t, input burst_t b, input logic rd,
                      input logic [3:0] eg, input logic [1:0] eo, input logic ev,
                      input logic em, input string nm);
    @(negedge clk);
    reset     = rs;
    bus.req   = r;
    bus.lock  = l;
    bus.trans = t;
    bus.burst = b;
    bus.ready = rd;
    expq.push_back({eg, eo, ev, em});
    nameq.push_back(nm);
  endtask

  // Monitor: after each rising edge, compare the registered outputs with the oldest expectation.
  initial begin
    logic [7:0] e;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        n = nameq.pop_front();
        tests++;
        if ({bus.grant, bus.owner, bus.ownerValid, bus.mastLock} !== e) begin
          fails++;
          $display("FAIL %s: got grant=%b owner=%0d ownerValid=%b mastLock=%b, expected grant=%b owner=%0d ownerValid=%b mastLock=%b",
                   n, bus.grant, bus.owner, bus.ownerValid, bus.mastLock,
                   e[7:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    bus.req   = '0;
    bus.lock  = '0;
    bus.trans = IDLE;
    bus.burst = SINGLE;
    bus.ready = 1'b1;

    // reset and parking
    step(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 0, 0, "reset");
    step(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 0, 0, "park_idle");
    // round robin between managers 1 and 2
    step(0, 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 4'b0010, 2'd1, 1, 0, "rr_first");
    step(0, 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 4'b0100, 2'd2, 1, 0, "rr_second");
    step(0, 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 4'b0010, 2'd1, 1, 0, "rr_wrap");
    // INCR4 by owner 1 with a wait state and a BUSY
    step(0, 4'b0110, 4'b0000, NONSEQ, INCR4,  1, 4'b0010, 2'd1, 1, 0, "b4_nonseq");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  0, 4'b0010, 2'd1, 1, 0, "b4_wait");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1, 4'b0010, 2'd1, 1, 0, "b4_seq1");
    step(0, 4'b0110, 4'b0000, BUSY,   INCR4,  1, 4'b0010, 2'd1, 1, 0, "b4_busy");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1, 4'b0010, 2'd1, 1, 0, "b4_seq2");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  0, 4'b0010, 2'd1, 1, 0, "b4_last_wait");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1, 4'b0100, 2'd2, 1, 0, "b4_handover");
    // locked sequence by manager 3 with everyone requesting
    step(0, 4'b1111, 4'b1000, IDLE,   SINGLE, 1, 4'b1000, 2'd3, 1, 1, "lk_grant");
    step(0, 4'b1111, 4'b1000, NONSEQ, INCR,   1, 4'b1000, 2'd3, 1, 1, "lk_nonseq");
    step(0, 4'b1111, 4'b1000, SEQ,    INCR,   1, 4'b1000, 2'd3, 1, 1, "lk_seq");
    step(0, 4'b1111, 4'b1000, IDLE,   SINGLE, 1, 4'b1000, 2'd3, 1, 1, "lk_idle_held");
    step(0, 4'b1111, 4'b0000, SEQ,    INCR,   1, 4'b1000, 2'd3, 1, 1, "lk_drop_seq");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 0, 4'b1000, 2'd3, 1, 1, "lk_idle_wait");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 1, 0, "lk_release");
    // reset in the middle of an INCR8
    step(0, 4'b1111, 4'b0000, NONSEQ, INCR8,  1, 4'b0001, 2'd0, 1, 0, "b8_nonseq");
    step(0, 4'b1111, 4'b0000, SEQ,    INCR8,  1, 4'b0001, 2'd0, 1, 0, "b8_seq1");
    step(0, 4'b1111, 4'b0000, SEQ,    INCR8,  1, 4'b0001, 2'd0, 1, 0, "b8_seq2");
    step(1, 4'b1111, 4'b0000, SEQ,    INCR8,  1, 4'b0001, 2'd0, 0, 0, "rst_midburst");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 1, 0, "rst_from0");
    // all four requesting: owners 0,1,2,3,0
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, 4'b0001, 2'd0, 1, 0, "rr4_s0");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, 4'b0010, 2'd1, 1, 0, "rr4_1");
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, 4'b0010, 2'd1, 1, 0, "rr4_s1");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, 4'b0100, 2'd2, 1, 0, "rr4_2");
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, 4'b0100, 2'd2, 1, 0, "rr4_s2");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, 4'b1000, 2'd3, 1, 0, "rr4_3");
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, 4'b1000, 2'd3, 1, 0, "rr4_s3");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 1, 0, "rr4_wrap");
    // sole requester regranted, then park
    step(0, 4'b0001, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 1, 0, "solo_regrant");
    step(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 0, 0, "park_again");
    // undefined-length INCR released only by IDLE
    step(0, 4'b0011, 4'b0000, IDLE,   SINGLE, 1, 4'b0010, 2'd1, 1, 0, "incr_grant");
    step(0, 4'b0011, 4'b0000, NONSEQ, INCR,   1, 4'b0010, 2'd1, 1, 0, "incr_nonseq");
    step(0, 4'b0011, 4'b0000, SEQ,    INCR,   1, 4'b0010, 2'd1, 1, 0, "incr_seq1");
    step(0, 4'b0011, 4'b0000, BUSY,   INCR,   1, 4'b0010, 2'd1, 1, 0, "incr_busy");
    step(0, 4'b0011, 4'b0000, SEQ,    INCR,   1, 4'b0010, 2'd1, 1, 0, "incr_seq2");
    step(0, 4'b0011, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 1, 0, "incr_release");
    // owner 0 drops req mid INCR4; the burst still completes
    step(0, 4'b0011, 4'b0000, NONSEQ, INCR4,  1, 4'b0001, 2'd0, 1, 0, "drop_nonseq");
    step(0, 4'b0010, 4'b0000, SEQ,    INCR4,  1, 4'b0001, 2'd0, 1, 0, "drop_seq1");
    step(0, 4'b0010, 4'b0000, SEQ,    INCR4,  1, 4'b0001, 2'd0, 1, 0, "drop_seq2");
    step(0, 4'b0010, 4'b0000, SEQ,    INCR4,  1, 4'b0010, 2'd1, 1, 0, "drop_handover");
    // lock raised by an existing owner at NONSEQ
    step(0, 4'b0011, 4'b0010, NONSEQ, SINGLE, 1, 4'b0010, 2'd1, 1, 1, "own_lock");
    step(0, 4'b0011, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 2'd0, 1, 0, "own_unlock");

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d checks still pending, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
